// File: rtl/cache_dados_refill.sv
// Direct-mapped write-through, no-write-allocate data cache for the MEM stage.
// Read misses refill a whole line beat by beat; every store is written through to memory.
module cache_dados_refill #(
  parameter int NUM_LINES      = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] endereco,
  input  logic [31:0]       dado_escrita,
  output logic [31:0]       dado_lido,
  output logic              stall_cache_dados,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_WRITE
  } state_t;

  state_t state, state_nx;

  logic [OFF_W-1:0] beat;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem [NUM_LINES];
  logic [WORDS_PER_LINE-1:0][31:0] data_mem [NUM_LINES];
  logic [WORDS_PER_LINE-1:0][31:0] line_buf;
  logic [WORDS_PER_LINE-1:0][31:0] line_nx;
  logic [TAG_W-1:0] cap_tag;
  logic [IDX_W-1:0] cap_idx;

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic hit;
  logic last_beat;
  logic addr_unused;

  assign off = endereco[OFF_W+1:2];
  assign idx = endereco[IDX_W+OFF_W+1:OFF_W+2];
  assign tag = endereco[ADDR_W-1:IDX_W+OFF_W+2];
  assign addr_unused = ^endereco[1:0];

  assign hit       = valid[idx] && (tag_mem[idx] == tag);
  assign last_beat = (beat == OFF_W'(WORDS_PER_LINE - 1));
  assign dado_lido = reset_n ? data_mem[idx][off] : 32'h0;

  // The last beat comes straight from mem_rdata so the line is committed on its ack.
  always_comb begin
    line_nx = line_buf;
    line_nx[WORDS_PER_LINE-1] = mem_rdata;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= S_IDLE;
      beat  <= '0;
      valid <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (MemRead && !hit) beat <= '0;
        end
        S_REFILL: begin
          if (mem_ack) begin
            beat <= beat + 1'b1;
            if (last_beat) valid[cap_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Arrays and capture registers survive reset; only valid bits are cleared.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (state == S_IDLE && MemRead && !hit) begin
        cap_tag <= tag;
        cap_idx <= idx;
      end
      if (state == S_REFILL && mem_ack) begin
        line_buf[beat] <= mem_rdata;
        if (last_beat) begin
          data_mem[cap_idx] <= line_nx;
          tag_mem[cap_idx]  <= cap_tag;
        end
      end
      if (state == S_WRITE && mem_ack && hit) data_mem[idx][off] <= dado_escrita;
    end
  end

  always_comb begin
    state_nx          = state;
    stall_cache_dados = 1'b0;
    mem_req           = 1'b0;
    mem_we            = 1'b0;
    mem_addr          = '0;
    mem_wdata         = '0;
    case (state)
      S_IDLE: begin
        if (MemRead && !hit) begin
          state_nx          = S_REFILL;
          stall_cache_dados = 1'b1;
        end else if (!MemRead && MemWrite) begin
          state_nx          = S_WRITE;
          stall_cache_dados = 1'b1;
        end
      end
      S_REFILL: begin
        mem_req           = 1'b1;
        mem_addr          = {cap_tag, cap_idx, beat, 2'b00};
        stall_cache_dados = 1'b1;
        if (mem_ack && last_beat) state_nx = S_IDLE;
      end
      S_WRITE: begin
        mem_req           = 1'b1;
        mem_we            = 1'b1;
        mem_addr          = {endereco[ADDR_W-1:2], 2'b00};
        mem_wdata         = dado_escrita;
        stall_cache_dados = !mem_ack;
        if (mem_ack) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (!reset_n) begin
      mem_req           = 1'b0;
      mem_we            = 1'b0;
      stall_cache_dados = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_dados_refill.sv
// Bench for cache_dados_refill: directed scenarios plus random traffic against a
// line-presence model and a flat word memory with a randomly delayed responder.
module tb_cache_dados_refill;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        MemRead, MemWrite;
  logic [31:0] endereco, dado_escrita;
  logic [31:0] dado_lido;
  logic        stall_cache_dados;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  cache_dados_refill dut (
    .clock(clock), .reset_n(reset_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .endereco(endereco), .dado_escrita(dado_escrita), .dado_lido(dado_lido),
    .stall_cache_dados(stall_cache_dados), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // model: memory words, and which tag each line currently holds
  logic [31:0] mem_m [bit [31:0]];
  bit          mv [32];
  logic [31:0] mt [32];

  // responder state and beat log
  bit in_beat = 0;
  int cnt = 0, cur_dly = 0, fixed_delay = -1;
  logic [31:0] b_addr[$], b_wd[$];
  bit          b_we[$];
  int          b_dly[$];

  logic s_stall, s_req, s_we;
  logic [31:0] s_lido;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic responder();
    mem_ack   = 1'b0;
    mem_rdata = $urandom();
    if (mem_req === 1'b1) begin
      if (!in_beat) begin
        in_beat = 1;
        cnt     = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 2));
        cur_dly = cnt;
      end
      if (cnt == 0) begin
        mem_ack   = 1'b1;
        in_beat   = 0;
        mem_rdata = mem_rd(mem_addr);
        b_addr.push_back(mem_addr);
        b_we.push_back(mem_we);
        b_wd.push_back(mem_wdata);
        b_dly.push_back(cur_dly);
      end else begin
        cnt--;
      end
    end
  endtask

  task automatic step();
    @(negedge clock);
    responder();
    #1;
    s_stall = stall_cache_dados;
    s_req   = mem_req;
    s_we    = mem_we;
    s_lido  = dado_lido;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    b_addr.delete(); b_we.delete(); b_wd.delete(); b_dly.delete();
  endtask

  // One pipeline access: holds the inputs until the stall drops, then checks
  // stall length, memory beats and load data against the model.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input string nm,
                        output int stalls, output int nb);
    int idx, exp_nb, exp_stall;
    logic [31:0] tg, base, waddr, exp_lido, got, ea;
    bit miss, store, done;
    idx   = int'((addr >> 4) & 32'h1F);
    tg    = addr >> 9;
    base  = addr & ~32'hF;
    waddr = addr & ~32'h3;
    miss  = rd && !(mv[idx] && mt[idx] == tg);
    store = !rd && wr;
    exp_lido = mem_rd(waddr);
    clear_log();
    MemRead = rd; MemWrite = wr; endereco = addr; dado_escrita = wd;
    stalls = 0; done = 0; got = '0;
    for (int c = 0; c < 60 && !done; c++) begin
      step();
      if (s_stall === 1'b0) begin done = 1; got = s_lido; end
      else stalls++;
    end
    nb = b_addr.size();
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s timeout: stall still %b after 60 cycles, required 0", nm, s_stall);
    end
    exp_nb = miss ? 4 : (store ? 1 : 0);
    n_tests++;
    if (nb != exp_nb) begin
      n_fail++;
      $display("FAIL %s beat_count: got %0d, required %0d", nm, nb, exp_nb);
    end else begin
      exp_stall = 0;
      if (miss) begin
        exp_stall = 1;
        foreach (b_dly[i]) exp_stall += b_dly[i] + 1;
      end else if (store) begin
        exp_stall = 1 + b_dly[0];
      end
      n_tests++;
      if (stalls != exp_stall) begin
        n_fail++;
        $display("FAIL %s stall_cycles: got %0d, required %0d", nm, stalls, exp_stall);
      end
      for (int i = 0; i < nb; i++) begin
        ea = miss ? base + 32'(4 * i) : waddr;
        n_tests++;
        if (b_addr[i] !== ea || b_we[i] !== store) begin
          n_fail++;
          $display("FAIL %s beat%0d: addr %h we %b, required addr %h we %b",
                   nm, i, b_addr[i], b_we[i], ea, store);
        end
        if (store) begin
          n_tests++;
          if (b_wd[i] !== wd) begin
            n_fail++;
            $display("FAIL %s wdata: got %h, required %h", nm, b_wd[i], wd);
          end
        end
      end
    end
    if (rd) begin
      n_tests++;
      if (got !== exp_lido) begin
        n_fail++;
        $display("FAIL %s dado_lido @%h: got %h, required %h", nm, addr, got, exp_lido);
      end
    end
    if (miss) begin mv[idx] = 1; mt[idx] = tg; end
    if (store) mem_m[waddr] = wd;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    MemRead = 0; MemWrite = 0; endereco = '0; dado_escrita = '0;
    step(); step();
    reset_n = 1'b1;
    in_beat = 0;
    foreach (mv[i]) mv[i] = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    MemRead = 1; MemWrite = 1; endereco = 32'h100; dado_escrita = 32'h1;
    step(); step();
    n_tests++;
    if (s_req !== 1'b0 || s_we !== 1'b0 || s_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: req %b we %b stall %b, required 0 0 0", s_req, s_we, s_stall);
    end
    n_tests++;
    if (s_lido !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_lido: got %h, required 0", s_lido);
    end
    MemRead = 0; MemWrite = 0;
    reset_n = 1'b1;
    foreach (mv[i]) mv[i] = 0;
    step();
    n_tests++;
    if (s_req !== 1'b0 || s_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: req %b stall %b, required 0 0", s_req, s_stall);
    end
  endtask

  task automatic test_refill();
    int st, nb;
    fixed_delay = 0;
    access(1, 0, 32'h100, 32'h0, "refill_0x100", st, nb);
    n_tests++;
    if (st != 5) begin
      n_fail++;
      $display("FAIL refill_latency: got %0d stall cycles, required 5", st);
    end
  endtask

  task automatic test_read_hit();
    int st, nb;
    access(1, 0, 32'h108, 32'h0, "hit_0x108", st, nb);
    n_tests++;
    if (st != 0 || nb != 0) begin
      n_fail++;
      $display("FAIL hit_no_req: stall %0d beats %0d, required 0 0", st, nb);
    end
  endtask

  task automatic test_store_hit();
    int st, nb;
    fixed_delay = 2;
    access(0, 1, 32'h104, 32'hDEADBEEF, "store_hit", st, nb);
    n_tests++;
    if (st != 3) begin
      n_fail++;
      $display("FAIL store_stall: got %0d, required 3", st);
    end
    fixed_delay = 0;
    access(1, 0, 32'h104, 32'h0, "load_after_store", st, nb);
    n_tests++;
    if (s_lido !== 32'hDEADBEEF || nb != 0) begin
      n_fail++;
      $display("FAIL store_hit_update: got %h beats %0d, required deadbeef 0", s_lido, nb);
    end
  endtask

  task automatic test_store_miss();
    int st, nb;
    access(0, 1, 32'h2000, 32'h1234, "store_miss", st, nb);
    access(1, 0, 32'h2000, 32'h0, "load_after_miss_store", st, nb);
    n_tests++;
    if (nb != 4) begin
      n_fail++;
      $display("FAIL no_allocate: got %0d beats, required 4", nb);
    end
  endtask

  task automatic test_eviction();
    int st, nb;
    access(1, 0, 32'h100, 32'h0, "evict_a", st, nb);
    access(1, 0, 32'h300, 32'h0, "evict_b", st, nb);
    access(1, 0, 32'h100, 32'h0, "evict_a_again", st, nb);
    n_tests++;
    if (nb != 4) begin
      n_fail++;
      $display("FAIL eviction_remiss: got %0d beats, required 4", nb);
    end
  endtask

  task automatic test_reset_mid_refill();
    int st, nb;
    bit reached;
    fixed_delay = 0;
    clear_log();
    MemRead = 1; MemWrite = 0; endereco = 32'h580;
    reached = 0;
    for (int c = 0; c < 20 && !reached; c++) begin
      step();
      if (b_addr.size() == 2) reached = 1;
    end
    n_tests++;
    if (!reached) begin
      n_fail++;
      $display("FAIL mid_refill_reach: got %0d beats, required 2", b_addr.size());
    end
    reset_n = 1'b0;
    step();
    n_tests++;
    if (s_req !== 1'b0 || s_stall !== 1'b0 || s_lido !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_refill_reset: req %b stall %b lido %h, required 0 0 0", s_req, s_stall, s_lido);
    end
    reset_n = 1'b1;
    MemRead = 0;
    in_beat = 0;
    foreach (mv[i]) mv[i] = 0;
    access(1, 0, 32'h580, 32'h0, "refill_after_reset", st, nb);
    n_tests++;
    if (nb != 4) begin
      n_fail++;
      $display("FAIL partial_discard: got %0d beats, required 4", nb);
    end
    access(1, 0, 32'h100, 32'h0, "valid_cleared", st, nb);
  endtask

  task automatic test_random();
    int st, nb, r;
    logic [31:0] a;
    fixed_delay = -1;
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 2) << 9) | ($urandom_range(14, 17) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      if (r <= 4)      access(1, 0, a, $urandom(), "rnd_load", st, nb);
      else if (r <= 7) access(0, 1, a, $urandom(), "rnd_store", st, nb);
      else if (r == 8) access(1, 1, a, $urandom(), "rnd_both", st, nb);
      else             access(0, 0, a, $urandom(), "rnd_nop", st, nb);
    end
    MemRead = 0; MemWrite = 0;
    step();
  endtask

  initial begin
    mem_ack = 0; mem_rdata = '0;
    test_reset();
    test_refill();
    test_read_hit();
    test_store_hit();
    test_store_miss();
    test_eviction();
    test_reset_mid_refill();
    test_random();
    do_reset();
    test_refill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
